// File: rtl/dot_matrix_scanner.sv
// Row-scan controller for the LED dot matrix: fetches one row word, shifts it into
// the column drivers, then blanks, latches, advances the row walking-one and dwells.
module dot_matrix_scanner #(
  parameter int COLS   = 32,
  parameter int ROWS   = 8,
  parameter int CLKDIV = 4,
  parameter int DWELL  = 1024,
  localparam int RW    = $clog2(ROWS)
) (
  input  logic            clk32mhz,
  input  logic            reset,
  input  logic            enable,
  output logic            rd_en,
  output logic [RW-1:0]   rd_row,
  input  logic [COLS-1:0] rd_data,
  output logic            frame_done,
  output logic            CSDI,
  output logic            CCLK,
  output logic            LE,
  output logic            RSDI,
  output logic            RCLK,
  output logic            OEB
);

  localparam int BW   = $clog2(COLS);
  localparam int PMAX = (2 * CLKDIV > DWELL) ? 2 * CLKDIV : DWELL;
  localparam int PW   = $clog2(PMAX);

  localparam logic [PW-1:0] P_HALF      = PW'(CLKDIV);
  localparam logic [PW-1:0] P_BIT_END   = PW'(2 * CLKDIV - 1);
  localparam logic [PW-1:0] P_PHASE_END = PW'(CLKDIV - 1);
  localparam logic [PW-1:0] P_DWELL_END = PW'(DWELL - 1);
  localparam logic [BW-1:0] B_LAST      = BW'(COLS - 1);
  localparam logic [RW-1:0] R_LAST      = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH0, S_FETCH1, S_SHIFT, S_BLANK, S_LATCH, S_ROWCLK, S_DWELL
  } state_t;

  state_t          r_state;
  logic [RW-1:0]   r_row;
  logic [PW-1:0]   r_phase;
  logic [BW-1:0]   r_bit;
  logic [COLS-1:0] r_sr;
  logic r_rd_en, r_frame_done, r_csdi, r_cclk, r_le, r_rsdi, r_rclk, r_oeb;

  state_t          w_state;
  logic [RW-1:0]   w_row;
  logic [PW-1:0]   w_phase;
  logic [BW-1:0]   w_bit;
  logic [COLS-1:0] w_sr;
  logic            w_row_drive;

  always_comb begin
    w_state = r_state;
    w_row   = r_row;
    w_phase = r_phase;
    w_bit   = r_bit;
    w_sr    = r_sr;
    case (r_state)
      S_IDLE:   if (enable) w_state = S_FETCH0;
      S_FETCH0: w_state = S_FETCH1;
      S_FETCH1: begin
        w_sr    = rd_data;
        w_phase = '0;
        w_bit   = '0;
        w_state = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_phase == P_BIT_END) begin
          w_phase = '0;
          w_sr    = {r_sr[COLS-2:0], 1'b0};
          if (r_bit == B_LAST) w_state = S_BLANK;
          else                 w_bit   = r_bit + 1'b1;
        end else begin
          w_phase = r_phase + 1'b1;
        end
      end
      S_BLANK, S_LATCH, S_ROWCLK: begin
        if (r_phase == P_PHASE_END) begin
          w_phase = '0;
          w_state = (r_state == S_BLANK) ? S_LATCH :
                    (r_state == S_LATCH) ? S_ROWCLK : S_DWELL;
        end else begin
          w_phase = r_phase + 1'b1;
        end
      end
      S_DWELL: begin
        if (r_phase == P_DWELL_END) begin
          w_phase = '0;
          w_row   = (r_row == R_LAST) ? '0 : r_row + 1'b1;
          w_state = enable ? S_FETCH0 : S_IDLE;
        end else begin
          w_phase = r_phase + 1'b1;
        end
      end
      default:  w_state = S_IDLE;
    endcase
    w_row_drive = (w_state == S_BLANK) || (w_state == S_LATCH) || (w_state == S_ROWCLK);
  end

  // Outputs are registered from the upcoming state so each pin matches the state it belongs to.
  always_ff @(posedge clk32mhz or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_phase      <= '0;
      r_bit        <= '0;
      r_sr         <= '0;
      r_rd_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_csdi       <= 1'b0;
      r_cclk       <= 1'b0;
      r_le         <= 1'b0;
      r_rsdi       <= 1'b0;
      r_rclk       <= 1'b0;
      r_oeb        <= 1'b1;
    end else begin
      r_state      <= w_state;
      r_row        <= w_row;
      r_phase      <= w_phase;
      r_bit        <= w_bit;
      r_sr         <= w_sr;
      r_rd_en      <= (w_state == S_FETCH0);
      r_frame_done <= (w_state == S_DWELL) && (w_phase == P_DWELL_END) && (w_row == R_LAST);
      r_csdi       <= (w_state == S_SHIFT) && w_sr[COLS-1];
      r_cclk       <= (w_state == S_SHIFT) && (w_phase >= P_HALF);
      r_le         <= (w_state == S_LATCH);
      r_rsdi       <= w_row_drive && (w_row == '0);
      r_rclk       <= (w_state == S_ROWCLK);
      r_oeb        <= w_row_drive || (w_state == S_IDLE);
    end
  end

  assign rd_en      = r_rd_en;
  assign rd_row     = r_row;
  assign frame_done = r_frame_done;
  assign CSDI       = r_csdi;
  assign CCLK       = r_cclk;
  assign LE         = r_le;
  assign RSDI       = r_rsdi;
  assign RCLK       = r_rclk;
  assign OEB        = r_oeb;

endmodule
